// File: rtl/send_queue.sv
// ============================================================================
// Module      : send_queue
// Description : In-order send request FIFO. The head entry is offered on two
//               independent channels and retires once both have accepted it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package send_queue_pkg;
    typedef struct packed {
        logic [7:0]  meta;
        logic [31:0] data;
    } message_t;

    typedef logic [7:0] passthrough_t;

    typedef struct packed {
        message_t     message;
        passthrough_t passthrough;
    } send_queue_data_t;
endpackage

module send_queue
    import send_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             request_decoder_send_queue_valid,
    output logic             send_queue_request_decoder_ready,
    input  send_queue_data_t request_decoder_send_queue_data,
    output logic             send_queue_network_valid,
    input  logic             network_send_queue_ready,
    output message_t         send_queue_network_data,
    output logic             send_queue_writeback_valid,
    input  logic             writeback_send_queue_ready,
    output passthrough_t     send_queue_writeback_data,
    output logic             send_queue_empty
);

    localparam int unsigned c_ptr_w = $clog2(DEPTH);
    localparam int unsigned c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    send_queue_data_t   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_net_done;
    logic               r_wb_done;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_net_fire;
    logic w_wb_fire;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full);

    // Handshake outputs depend only on registered state, never on the far side's ready.
    assign send_queue_request_decoder_ready = !w_full;
    assign send_queue_network_valid         = !w_empty && !r_net_done;
    assign send_queue_writeback_valid       = !w_empty && !r_wb_done;
    assign send_queue_empty                 = w_empty;
    assign send_queue_network_data          = r_mem[r_rd_ptr].message;
    assign send_queue_writeback_data        = r_mem[r_rd_ptr].passthrough;

    assign w_push     = request_decoder_send_queue_valid && send_queue_request_decoder_ready;
    assign w_net_fire = send_queue_network_valid && network_send_queue_ready;
    assign w_wb_fire  = send_queue_writeback_valid && writeback_send_queue_ready;

    // The head retires in the cycle its second (or both) outstanding handshakes complete.
    assign w_pop = (r_net_done || w_net_fire) && (r_wb_done || w_wb_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_net_done <= 1'b0;
            r_wb_done  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + c_ptr_w'(1);
                r_net_done <= 1'b0;
                r_wb_done  <= 1'b0;
            end else begin
                if (w_net_fire) begin
                    r_net_done <= 1'b1;
                end
                if (w_wb_fire) begin
                    r_wb_done <= 1'b1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; contents are only observed while valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= request_decoder_send_queue_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_send_queue.sv
// ============================================================================
// Module      : tb_send_queue
// Description : Randomized scoreboard bench for send_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_send_queue;
    import send_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             dv;
    logic             dready;
    send_queue_data_t ddata;
    logic             nvalid;
    logic             nready;
    message_t         ndata;
    logic             wvalid;
    logic             wready;
    passthrough_t     wdata;
    logic             empty;

    send_queue #(.DEPTH(DEPTH)) dut (
        .clk                              (clk),
        .rst_n                            (rst_n),
        .request_decoder_send_queue_valid (dv),
        .send_queue_request_decoder_ready (dready),
        .request_decoder_send_queue_data  (ddata),
        .send_queue_network_valid         (nvalid),
        .network_send_queue_ready         (nready),
        .send_queue_network_data          (ndata),
        .send_queue_writeback_valid       (wvalid),
        .writeback_send_queue_ready       (wready),
        .send_queue_writeback_data        (wdata),
        .send_queue_empty                 (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        send_queue_data_t d;
        bit               net_sent;
        bit               wb_sent;
    } ent_t;

    ent_t model_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_push = 0;
    int   n_net  = 0;
    int   n_wb   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic send_queue_data_t mk(input logic [7:0] meta, input logic [31:0] data,
                                            input logic [7:0] pt);
        send_queue_data_t d;
        d.message.meta = meta;
        d.message.data = data;
        d.passthrough  = pt;
        return d;
    endfunction

    // Monitor: compares the DUT against the queue model, then advances the model
    // by the handshakes that the upcoming rising edge will complete.
    bit exp_rdy, exp_nv, exp_wv, nf, wf;
    always @(negedge clk) begin
        if (!rst_n) begin
            model_q.delete();
            n_push = 0; n_net = 0; n_wb = 0;
            check("reset_ready", 64'(dready), 64'd1);
            check("reset_nvalid", 64'(nvalid), 64'd0);
            check("reset_wvalid", 64'(wvalid), 64'd0);
            check("reset_empty", 64'(empty), 64'd1);
        end else begin
            exp_rdy = model_q.size() < DEPTH;
            exp_nv  = model_q.size() > 0 && !model_q[0].net_sent;
            exp_wv  = model_q.size() > 0 && !model_q[0].wb_sent;
            check("ready", 64'(dready), 64'(exp_rdy));
            check("empty", 64'(empty), 64'(model_q.size() == 0));
            check("net_valid", 64'(nvalid), 64'(exp_nv));
            check("wb_valid", 64'(wvalid), 64'(exp_wv));
            if (exp_nv) check("net_data", 64'(ndata), 64'(model_q[0].d.message));
            if (exp_wv) check("wb_data", 64'(wdata), 64'(model_q[0].d.passthrough));
            if (nvalid && nready) n_net++;
            if (wvalid && wready) n_wb++;
            if (dv && dready) n_push++;
            nf = exp_nv && nready;
            wf = exp_wv && wready;
            if (nf) model_q[0].net_sent = 1'b1;
            if (wf) model_q[0].wb_sent = 1'b1;
            if (model_q.size() > 0 && model_q[0].net_sent && model_q[0].wb_sent)
                void'(model_q.pop_front());
            if (dv && exp_rdy) model_q.push_back('{d: ddata, net_sent: 1'b0, wb_sent: 1'b0});
        end
    end

    task automatic offer(input send_queue_data_t d);
        dv = 1'b1;
        ddata = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dready) begin
                @(posedge clk);
                #1;
                dv = 1'b0;
                return;
            end
        end
        check("offer_timeout", 64'd1, 64'd0);
        dv = 1'b0;
    endtask

    task automatic drain();
        nready = 1'b1;
        wready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (empty && model_q.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    bit acc;
    initial begin
        rst_n = 1'b0;
        dv = 1'b0;
        ddata = '0;
        nready = 1'b0;
        wready = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Single send with both sides ready
        nready = 1'b1; wready = 1'b1;
        offer(mk(8'h11, 32'hA5, 8'h03));
        idle(3);

        // Split completion: writeback stalled for 5 cycles
        nready = 1'b1; wready = 1'b0;
        offer(mk(8'h22, 32'h1234_5678, 8'h44));
        idle(5);
        wready = 1'b1;
        idle(3);
        check("split_net_fires", 64'(n_net), 64'(n_push));
        check("split_wb_fires", 64'(n_wb), 64'(n_push));

        // Fill, stall a fifth offer, then release
        nready = 1'b0; wready = 1'b0;
        for (int i = 0; i < 4; i++) offer(mk(8'(i), 32'(i * 3 + 1), 8'(i)));
        dv = 1'b1; ddata = mk(8'h04, 32'h4, 8'h04);
        idle(3);
        nready = 1'b1; wready = 1'b1;
        offer(mk(8'h04, 32'h4, 8'h04));
        drain();

        // Streaming, continuous valid
        nready = 1'b1; wready = 1'b1;
        for (int i = 0; i < 16; i++) offer(mk(8'(8'h40 + i), $urandom, 8'($urandom)));
        drain();

        // Simultaneous push and pop at two held entries
        nready = 1'b0; wready = 1'b0;
        offer(mk(8'hA0, 32'hA0, 8'hA0));
        offer(mk(8'hA1, 32'hA1, 8'hA1));
        nready = 1'b1; wready = 1'b1;
        offer(mk(8'hA2, 32'hA2, 8'hA2));
        drain();

        // Asynchronous reset with three entries held and head network-complete
        nready = 1'b1; wready = 1'b0;
        for (int i = 0; i < 3; i++) offer(mk(8'(8'hC0 + i), 32'hC0, 8'hC0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_nvalid", 64'(nvalid), 64'd0);
        check("async_wvalid", 64'(wvalid), 64'd0);
        check("async_empty", 64'(empty), 64'd1);
        check("async_ready", 64'(dready), 64'd1);
        idle(2);
        rst_n = 1'b1;
        nready = 1'b1; wready = 1'b1;
        offer(mk(8'hD0, 32'hD00D, 8'hD0));
        drain();

        // Randomized traffic with random backpressure on both outputs
        acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            acc = dv && dready;
            @(posedge clk);
            #1;
            nready = 1'($urandom);
            wready = 1'($urandom);
            if (!dv || acc) begin
                dv = ($urandom % 3) != 0;
                ddata = mk(8'($urandom), $urandom, 8'($urandom));
            end
        end
        dv = 1'b0;
        drain();
        check("final_net_fires", 64'(n_net), 64'(n_push));
        check("final_wb_fires", 64'(n_wb), 64'(n_push));
        check("final_empty", 64'(empty), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/send_queue.md
# send_queue

Buffers decoded send requests between the request decoder and the outbound message path. Each accepted request is held in an in-order FIFO. The head entry is offered to the network interface (its message) and to the writeback stage (its passthrough) on two independent valid/ready channels. An entry retires only after both channels have completed their handshakes, which gives the core in-order send completion under backpressure from either side.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, ≥ 2.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- request_decoder_send_queue_valid  in  1  decoder offers a send request.
- send_queue_request_decoder_ready  out  1  queue can accept a request this cycle.
- request_decoder_send_queue_data  in  send_queue_data_t  {message{meta,data}, passthrough}.
- send_queue_network_valid  out  1  head message offered to network.
- network_send_queue_ready  in  1  network accepts the message.
- send_queue_network_data  out  message_t  head message.
- send_queue_writeback_valid  out  1  head passthrough offered to writeback.
- writeback_send_queue_ready  in  1  writeback accepts.
- send_queue_writeback_data  out  passthrough_t  head passthrough.
- send_queue_empty  out  1  no entries held (count == 0).

## Operation
- Storage: DEPTH-entry array of send_queue_data_t, with rd_ptr and wr_ptr of $clog2(DEPTH) bits that wrap naturally modulo DEPTH, plus count of $clog2(DEPTH)+1 bits.
- Push: on valid & ready, write data at wr_ptr, then wr_ptr+1.
- ready = (count != DEPTH). No same-cycle pop bypass, so ready is low when full even if a pop happens that cycle.
- Head tracking: two flags, net_done and wb_done, both reset to 0.
- network_valid = !empty & !net_done.
- writeback_valid = !empty & !wb_done.
- Network fire (valid & ready) sets net_done. Writeback fire sets wb_done.
- Pop occurs in the cycle where the head becomes fully complete: (net_done | net_fire) & (wb_done | wb_fire). Both fires in the same cycle also count.
- On pop: rd_ptr+1, and both flags clear to 0 for the next head.
- count: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Data outputs always show mem[rd_ptr]. Their value is don't-care when empty, and the bench must not check them then.
- Each entry produces exactly one network fire and exactly one writeback fire, in FIFO order.
- Reset mid-operation: all entries are discarded, pointers, count and flags go to 0, and no handshake completes during reset.

## Timing
- Reset values: decoder_ready = 1, network_valid = 0, writeback_valid = 0, empty = 1. Data outputs are unspecified.
- Latency: a push at edge N into an empty queue gives both valids high in cycle N+1. There is no combinational path from request input to any output.
- All outputs are functions of registered state only. Ready and valid are never combinationally dependent on the opposite side's ready.
- Valid, once asserted, holds with stable data until its own fire (AXI-style), even while the other channel is stalled.
- Full throughput: with both readies held high, the queue pops one entry per cycle and sustains one push per cycle.
- Full boundary: count == DEPTH means ready = 0. A pop at edge N makes ready = 1 in cycle N+1.
- Empty boundary: a pop of the last entry at edge N makes both valids 0 in cycle N+1, unless a push also occurred at edge N.

## Test plan
- Reset then single send {meta=0x11, data=0xA5, pt=3} with both readies high:
  - Both valids rise 1 cycle after push, with matching data.
  - Pop happens on that cycle; empty returns to 1 the following cycle.
- Split completion: network_ready=1, writeback_ready=0 for 5 cycles, then 1:
  - network_valid drops after its single fire.
  - writeback_valid stays high with pt stable.
  - Entry pops on the writeback fire, with exactly one fire per channel.
- Fill DEPTH=4 with both readies 0:
  - decoder_ready falls after the 4th push; a 5th offer is stalled.
  - Release both readies; outputs drain in order 0,1,2,3, and ready is 1 again one cycle after the first pop.
- Streaming 16 requests with both readies 1 and continuous valid:
  - One pop per cycle, pointers wrap correctly, order preserved, count never exceeds 2.
- Simultaneous push and pop at count=2:
  - count stays 2.
  - The new entry appears at head after the two older ones.
- Assert rst_n low while 3 entries are held and net_done is set:
  - Valids go to 0 immediately (asynchronously); empty=1 and ready=1.
  - After release, a new send is output without any stale entries.
